cl3641ah_scan_capture: RTL
==========================

# cl3641ah_scan_capture

Receive-side counterpart of the CL3641AH display driver: samples a multiplexed seven-segment bus (segment lines plus four active-low digit selects) and reconstructs the four per-digit segment patterns. It rejects glitches and overlapping selects, flags completed scan frames, and reports a stale display when scanning stops. It sits on the board-test / self-check path, wired to the same pins the driver produces, so a bench or on-chip monitor can read back what is being displayed.

## Interface
- STABLE_CYCLES, 4: consecutive identical samples needed to accept a digit; legal range 2..255.
- TIMEOUT_CYCLES, 65536: cycles without an accepted digit before `stale` asserts; legal range 2..2^24.
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- seven_seg  input  7  segment lines, active high, bit 0 = segment a.
- control  input  4  digit selects, active low; control[0]→a, [1]→b, [2]→c, [3]→d.
- a, b, c, d  output  7 each  last accepted segment pattern per digit.
- digit_valid  output  4  bit i set once digit i has been accepted since reset or last timeout.
- frame_done  output  1  one-cycle pulse when all four digits have been accepted in the current frame.
- bad_select  output  1  one-cycle pulse on entry into a multiple-select condition.
- stale  output  1  level, high while no digit has been accepted for TIMEOUT_CYCLES.

## Operation
- Input stage: `seven_seg` and `control` are registered every cycle into s_seg/s_ctl. All decisions use the registered copies.
- Select classification of s_ctl: NONE (4'b1111), ONE (exactly one bit low), MULTI (two or more bits low).
- State machine:
  - IDLE: s_ctl is NONE or MULTI. Go to TRACK when the class becomes ONE, setting run count to 1.
  - TRACK: while {s_seg, s_ctl} is unchanged, the run count increments. A change to another ONE value restarts the count at 1. A change to NONE or MULTI goes to IDLE. When the count reaches STABLE_CYCLES, accept and go to HELD.
  - HELD: no further accepts while the value is unchanged. A change to another ONE value (new digit, or same digit with a new pattern) goes to TRACK with count 1. NONE or MULTI goes to IDLE.
- Accept: write s_seg into the selected digit register, set the matching bits in digit_valid and in the internal frame mask, clear stale, and zero the timeout counter.
- Frame: when an accept makes the frame mask 4'b1111, pulse frame_done and clear the mask on the same edge. Re-accepting a digit whose mask bit is already set has no frame effect.
- MULTI: bad_select pulses once on the NONE/ONE→MULTI transition. The frame mask clears (frame aborted). Digit registers and digit_valid are untouched.
- Timeout: the counter increments every cycle without an accept and saturates. On reaching TIMEOUT_CYCLES, stale is set, digit_valid clears to 0, and the frame mask clears. Digit registers hold their values.
- Counters are sized by $clog2 of their parameter. The run counter saturates in HELD and never wraps.

## Timing
- Reset (reset low at a rising edge) applies to all outputs: a–d = 0, digit_valid = 0, frame_done = 0, bad_select = 0, stale = 0. It also clears state to IDLE and zeros the counters and s_seg/s_ctl. Reset mid-acquisition discards partial counts, and acquisition restarts from IDLE on the first edge with reset high.
- Accept latency: a valid {seven_seg, control} value set up before edge n and held constant is registered at edge n. The outputs update at edge n+STABLE_CYCLES-1+1, i.e. STABLE_CYCLES edges after edge n. frame_done rises on that same edge.
- A value held for fewer than STABLE_CYCLES registered samples is never accepted.
- bad_select is high for exactly the cycle after the edge on which s_ctl first becomes MULTI.
- stale rises on the edge where the counter reaches TIMEOUT_CYCLES, i.e. TIMEOUT_CYCLES edges after the last accept or reset release. It falls on the next accept edge.
- Simultaneous accept and timeout on the same edge: the accept wins, so stale stays 0 and the counter restarts.

## Test plan
- Defaults, driver-style scan: hold a=7'h06 (ctl 4'b1110), b=7'h5B (1101), c=7'h4F (1011), d=7'h66 (0111), each for 10 cycles. Required: outputs match, digit_valid = 4'hF, frame_done pulses once at the edge d is accepted (4 edges after its first registered sample).
- Glitch rejection: ctl 4'b1110 with seg 7'h7F held 3 cycles, then ctl 4'b1111. Required: a stays 0 and digit_valid[0] stays 0. The same value held 4 cycles is accepted.
- Overlap: ctl 4'b1100 for 6 cycles mid-frame after a and b are accepted. Required: one bad_select pulse, no digit writes, and no frame_done until a, b, c, d are all re-accepted.
- In-place change: digit c accepted as 7'h4F, then its pattern switches to 7'h7D with ctl unchanged. Required: c = 7'h7D exactly 4 edges after the change is registered.
- Timeout: TIMEOUT_CYCLES=16, full frame, then all selects high. Required: stale = 1 and digit_valid = 0 at the 16th edge after the last accept, a–d retained. The next accept clears stale.
- Reset mid-track: reset low for 1 edge at run count 3. Required: all outputs zero, and the next value needs a full 4 samples to be accepted.

Source files
------------

// File: rtl/cl3641ah_scan_capture_if.sv
// Pin-level bundle between a CL3641AH-style scan driver and the scan capture block.
// The master drives the multiplexed bus; the slave reconstructs and reports the digits.
interface cl3641ah_scan_capture_if;
    logic [6:0] seven_seg;
    logic [3:0] control;
    logic [6:0] a;
    logic [6:0] b;
    logic [6:0] c;
    logic [6:0] d;
    logic [3:0] digit_valid;
    logic       frame_done;
    logic       bad_select;
    logic       stale;

    modport master (
        output seven_seg, control,
        input  a, b, c, d, digit_valid, frame_done, bad_select, stale
    );

    modport slave (
        input  seven_seg, control,
        output a, b, c, d, digit_valid, frame_done, bad_select, stale
    );
endinterface

// File: rtl/cl3641ah_scan_capture.sv
// Reconstructs four seven-segment digit patterns from a multiplexed scan bus,
// with glitch filtering, overlap detection, frame completion and stale-display reporting.
module cl3641ah_scan_capture #(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input logic                    clk,
    input logic                    reset,
    cl3641ah_scan_capture_if.slave bus
);

    localparam int RUN_W = $clog2(STABLE_CYCLES + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [RUN_W-1:0] RUN_ONE    = RUN_W'(1);
    localparam logic [RUN_W-1:0] RUN_ACCEPT = RUN_W'(STABLE_CYCLES - 1);
    localparam logic [RUN_W-1:0] RUN_FULL   = RUN_W'(STABLE_CYCLES);
    localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_FULL   = TMO_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_ONE,
        SEL_MULTI
    } sel_class_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_TRACK,
        ST_HELD
    } state_t;

    function automatic sel_class_t classify(input logic [3:0] ctl);
        int lows;
        lows = 0;
        for (int i = 0; i < 4; i++) begin
            if (!ctl[i]) lows++;
        end
        if (lows == 0)      return SEL_NONE;
        else if (lows == 1) return SEL_ONE;
        else                return SEL_MULTI;
    endfunction

    // Registered input samples and classification
    logic [6:0]       s_seg;
    logic [3:0]       s_ctl;
    sel_class_t       s_class;
    logic             s_multi;
    logic             s_multi_q;

    // Tracking state
    state_t           state_q, state_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic [6:0]       trk_seg_q, trk_seg_d;
    logic [3:0]       trk_ctl_q, trk_ctl_d;
    logic             same;
    logic             accept;

    // Output-side state
    logic [6:0]       digit_q [4];
    logic [3:0]       valid_q;
    logic [3:0]       mask_q;
    logic [3:0]       sel_onehot;
    logic [3:0]       mask_next;
    logic             frame_done_q;
    logic             stale_q;
    logic [TMO_W-1:0] tmo_q;

    assign s_class    = classify(s_ctl);
    assign s_multi    = (s_class == SEL_MULTI);
    assign same       = (s_seg == trk_seg_q) && (s_ctl == trk_ctl_q);
    assign sel_onehot = ~s_ctl;
    assign mask_next  = mask_q | sel_onehot;

    always_comb begin
        state_d   = state_q;
        run_d     = run_q;
        trk_seg_d = trk_seg_q;
        trk_ctl_d = trk_ctl_q;
        accept    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (s_class == SEL_ONE) begin
                    state_d   = ST_TRACK;
                    run_d     = RUN_ONE;
                    trk_seg_d = s_seg;
                    trk_ctl_d = s_ctl;
                end
            end
            ST_TRACK: begin
                if (s_class != SEL_ONE) begin
                    state_d = ST_IDLE;
                    run_d   = '0;
                end else if (!same) begin
                    run_d     = RUN_ONE;
                    trk_seg_d = s_seg;
                    trk_ctl_d = s_ctl;
                end else if (run_q == RUN_ACCEPT) begin
                    // This sample is the STABLE_CYCLES-th identical one
                    accept  = 1'b1;
                    run_d   = RUN_FULL;
                    state_d = ST_HELD;
                end else begin
                    run_d = run_q + RUN_ONE;
                end
            end
            ST_HELD: begin
                if (s_class != SEL_ONE) begin
                    state_d = ST_IDLE;
                    run_d   = '0;
                end else if (!same) begin
                    state_d   = ST_TRACK;
                    run_d     = RUN_ONE;
                    trk_seg_d = s_seg;
                    trk_ctl_d = s_ctl;
                end
            end
            default: begin
                state_d = ST_IDLE;
                run_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            s_seg        <= '0;
            s_ctl        <= '0;
            // A zeroed s_ctl classifies as MULTI, so the edge detector starts there
            s_multi_q    <= 1'b1;
            state_q      <= ST_IDLE;
            run_q        <= '0;
            trk_seg_q    <= '0;
            trk_ctl_q    <= '0;
            for (int i = 0; i < 4; i++) digit_q[i] <= '0;
            valid_q      <= '0;
            mask_q       <= '0;
            frame_done_q <= 1'b0;
            stale_q      <= 1'b0;
            tmo_q        <= '0;
        end else begin
            s_seg        <= bus.seven_seg;
            s_ctl        <= bus.control;
            s_multi_q    <= s_multi;
            state_q      <= state_d;
            run_q        <= run_d;
            trk_seg_q    <= trk_seg_d;
            trk_ctl_q    <= trk_ctl_d;
            frame_done_q <= 1'b0;
            if (accept) begin
                for (int i = 0; i < 4; i++) begin
                    if (sel_onehot[i]) digit_q[i] <= s_seg;
                end
                valid_q <= valid_q | sel_onehot;
                if (mask_next == 4'hF) begin
                    frame_done_q <= 1'b1;
                    mask_q       <= '0;
                end else begin
                    mask_q <= mask_next;
                end
                stale_q <= 1'b0;
                tmo_q   <= '0;
            end else begin
                if (tmo_q != TMO_FULL) tmo_q <= tmo_q + TMO_W'(1);
                if (s_multi) mask_q <= '0;
                if (tmo_q == TMO_LAST) begin
                    stale_q <= 1'b1;
                    valid_q <= '0;
                    mask_q  <= '0;
                end
            end
        end
    end

    assign bus.a           = digit_q[0];
    assign bus.b           = digit_q[1];
    assign bus.c           = digit_q[2];
    assign bus.d           = digit_q[3];
    assign bus.digit_valid = valid_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.bad_select  = s_multi && !s_multi_q;
    assign bus.stale       = stale_q;

endmodule
